// File: rtl/ifetch_prefetch_if.sv
// Fetch-stage bundle: core-side lookup (iaddr/idata/ivalid) plus the
// req/gnt/rvalid instruction memory read port.
interface ifetch_prefetch_if;
    logic [31:0] iaddr;
    logic [31:0] idata;
    logic        ivalid;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        input  iaddr,
        output idata, ivalid,
        output mem_req, mem_addr,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        output iaddr,
        input  idata, ivalid,
        input  mem_req, mem_addr,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/ifetch_prefetch.sv
// Instruction prefetcher: DEPTH-entry sequential FIFO in front of a pipelined
// word-read port; non-sequential iaddr flushes and drops in-flight responses.
module ifetch_prefetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          DEPTH        = 4
) (
    input  logic              clk,
    input  logic              rstn,
    ifetch_prefetch_if.master bus
);
    localparam int            PW      = $clog2(DEPTH);
    localparam int            CW      = PW + 1;
    localparam logic [29:0]   RV_W    = RESET_VECTOR[31:2];
    localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);

    logic [29:0]   r_head_addr;
    logic [29:0]   r_fetch_addr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_outst;
    logic [CW-1:0] r_drop;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [31:0]   r_fifo [DEPTH];

    logic [29:0]   w_k;
    logic          w_k_zero;
    logic          w_k_one;
    logic          w_skip;
    logic          w_flush;
    logic          w_hit;
    logic          w_grant;
    logic          w_drop_resp;
    logic          w_push;
    logic [CW-1:0] w_pop;
    logic [CW-1:0] w_outst_next;
    logic [CW:0]   w_occ;

    // Word distance from the FIFO head; mod-2^30 so address wrap needs no case.
    assign w_k      = bus.iaddr[31:2] - r_head_addr;
    assign w_k_zero = (w_k == '0);
    assign w_k_one  = (w_k == 30'd1);
    assign w_skip   = !w_k_zero && (w_k < {{(30-CW){1'b0}}, r_count});
    assign w_flush  = !w_k_zero && !w_skip;
    assign w_pop    = w_skip ? w_k[CW-1:0] : '0;

    // A one-word step hits on entry[1] so straight-line code sees no bubble.
    assign w_hit      = rstn && ((w_k_zero && (r_count != '0)) || (w_skip && w_k_one));
    assign bus.ivalid = w_hit;
    assign bus.idata  = w_hit ? r_fifo[r_rd_ptr + PW'(w_k_one)] : '0;

    // Outstanding reads count against FIFO space so every response has a slot.
    assign w_occ        = {1'b0, r_count} + {1'b0, r_outst};
    assign bus.mem_req  = rstn && !w_flush && (w_occ < DEPTH_C);
    assign bus.mem_addr = {r_fetch_addr, 2'b00};
    assign w_grant      = bus.mem_req && bus.mem_gnt;

    assign w_drop_resp  = bus.mem_rvalid && (w_flush || (r_drop != '0));
    assign w_push       = bus.mem_rvalid && !w_drop_resp;
    assign w_outst_next = r_outst + CW'(w_grant) - CW'(bus.mem_rvalid);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_head_addr  <= RV_W;
            r_fetch_addr <= RV_W;
            r_count      <= '0;
            r_outst      <= '0;
            r_drop       <= '0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
        end else begin
            r_outst <= w_outst_next;
            if (w_flush) begin
                r_head_addr  <= bus.iaddr[31:2];
                r_fetch_addr <= bus.iaddr[31:2];
                r_count      <= '0;
                r_drop       <= w_outst_next;
                r_rd_ptr     <= '0;
                r_wr_ptr     <= '0;
            end else begin
                r_head_addr  <= r_head_addr + {{(30-CW){1'b0}}, w_pop};
                r_fetch_addr <= r_fetch_addr + 30'(w_grant);
                r_count      <= r_count - w_pop + CW'(w_push);
                r_rd_ptr     <= r_rd_ptr + w_pop[PW-1:0];
                if (bus.mem_rvalid && (r_drop != '0)) r_drop <= r_drop - CW'(1);
                if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= bus.mem_rdata;
    end
endmodule

// File: tb/tb_ifetch_prefetch.sv
// Bench for ifetch_prefetch: in-order random-latency memory, a core that stalls
// on !ivalid, directed scenarios and a random run checked against memory contents.
module tb_ifetch_prefetch;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RV    = 32'h0000_0000;

    typedef struct {
        logic [31:0] addr;
        int          cyc;
    } gnt_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    ifetch_prefetch_if bus();
    ifetch_prefetch #(.RESET_VECTOR(RV), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          gnt_pct = 100;
    int          rv_pct = 100;
    int          mode = 0;
    bit          seq_chk = 1'b0;
    gnt_t        q[$];
    logic [31:0] next_iaddr = RV;
    logic [31:0] last_grant = 32'h0;
    logic [31:0] s_iaddr, s_data, s_maddr;
    logic        s_vld, s_req;
    int          stall = 0;
    int          max_stall = 0;

    // Memory contents are a fixed function of the word address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[31:2], 2'b00} * 32'h9E37_79B1 + 32'h5BD1_E995;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One clock: drive memory and core at negedge, sample 1ns later.
    task automatic tick();
        int   r;
        gnt_t g;
        @(negedge clk);
        if (q.size() > 0 && q[0].cyc < cyc && $urandom_range(99) < rv_pct) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = memf(q[0].addr);
            void'(q.pop_front());
        end else begin
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = $urandom;
        end
        bus.mem_gnt = ($urandom_range(99) < gnt_pct);
        bus.iaddr   = next_iaddr;
        #1;
        s_iaddr = next_iaddr;
        s_vld   = bus.ivalid;
        s_data  = bus.idata;
        s_req   = bus.mem_req;
        s_maddr = bus.mem_addr;
        if (s_vld) chk("idata", s_data, memf(s_iaddr));
        else       chk("idata_idle", s_data, 32'h0);
        if (s_req && bus.mem_gnt) begin
            chk("maddr_align", {30'h0, s_maddr[1:0]}, 32'h0);
            if (seq_chk) chk("seq_grant", s_maddr, last_grant + 32'd4);
            last_grant = s_maddr;
            g.addr = s_maddr;
            g.cyc  = cyc;
            q.push_back(g);
        end
        chk("outst_cap", 32'(q.size() <= DEPTH), 32'd1);
        if (s_vld) stall = 0;
        else       stall++;
        if (stall > max_stall) max_stall = stall;
        case (mode)
            1: if (s_vld) next_iaddr = s_iaddr + 32'd4;
            2: if (s_vld) begin
                r = $urandom_range(99);
                if (r < 70)      next_iaddr = s_iaddr + 32'd4;
                else if (r < 82) next_iaddr = s_iaddr + 32'(4 * $urandom_range(2, 4));
                else if (r < 92) next_iaddr = 32'h1000 + 32'($urandom_range(1023)) * 32'd4;
                else             next_iaddr = s_iaddr - 32'(4 * $urandom_range(1, 6));
                next_iaddr[1:0] = 2'($urandom_range(3));
            end
            default: ;
        endcase
        cyc++;
    endtask

    initial begin
        logic [5:0] exp_req;
        logic [5:0] exp_vld;
        bit         reached;
        exp_req = 6'b001111;
        exp_vld = 6'b111100;
        bus.iaddr      = RV;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ivalid", 32'(bus.ivalid), 32'd0);
        chk("rst_idata", bus.idata, 32'h0);
        chk("rst_req", 32'(bus.mem_req), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("cold_req_first", 32'(bus.mem_req), 32'd1);
        chk("cold_addr_first", bus.mem_addr, RV);

        // Cold start, 1-cycle memory, core parked at the reset vector
        for (int n = 0; n < 6; n++) begin
            tick();
            chk("cold_req", 32'(s_req), 32'(exp_req[n]));
            if (s_req) chk("cold_addr", s_maddr, 32'(4 * n));
            chk("cold_vld", 32'(s_vld), 32'(exp_vld[n]));
        end

        // Sequential run: one instruction per cycle, one grant per word
        next_iaddr = 32'h4;
        mode       = 1;
        seq_chk    = 1'b1;
        for (int n = 0; n < 40; n++) begin
            tick();
            chk("seq_vld", 32'(s_vld), 32'd1);
            if (s_iaddr == 32'h40) break;
        end
        chk("seq_reach", s_iaddr, 32'h40);
        seq_chk = 1'b0;

        // Branch flush with three reads in flight
        mode       = 0;
        next_iaddr = 32'h40;
        repeat (6) tick();
        rv_pct     = 0;
        next_iaddr = 32'h10;
        tick();
        chk("br1_req", 32'(s_req), 32'd0);
        chk("br1_vld", 32'(s_vld), 32'd0);
        repeat (3) tick();
        gnt_pct    = 0;
        next_iaddr = 32'h200;
        tick();
        chk("br2_req", 32'(s_req), 32'd0);
        chk("br2_inflight", 32'(q.size()), 32'd3);
        gnt_pct = 100;
        rv_pct  = 100;
        for (int n = 1; n <= 5; n++) begin
            tick();
            chk("br2_vld", 32'(s_vld), 32'(n == 5));
        end

        // Short forward branch inside the FIFO
        next_iaddr = 32'h20;
        repeat (9) tick();
        next_iaddr = 32'h28;
        tick();
        chk("skip_vld", 32'(s_vld), 32'd0);
        chk("skip_req", 32'(s_req), 32'd0);
        tick();
        chk("skip_hit", 32'(s_vld), 32'd1);
        chk("skip_noflush_req", 32'(s_req), 32'd1);
        chk("skip_noflush_addr", s_maddr, 32'h30);

        // Backpressure on an empty FIFO
        gnt_pct    = 0;
        next_iaddr = 32'h300;
        tick();
        chk("bp_flush_req", 32'(s_req), 32'd0);
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("bp_req", 32'(s_req), 32'd1);
            chk("bp_addr", s_maddr, 32'h300);
            chk("bp_vld", 32'(s_vld), 32'd0);
        end
        gnt_pct = 100;
        for (int n = 1; n <= 3; n++) begin
            tick();
            chk("bp_resume_vld", 32'(s_vld), 32'(n == 3));
        end

        // Reset asserted with two reads outstanding
        rv_pct     = 0;
        next_iaddr = 32'h400;
        repeat (3) tick();
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("mrst_vld", 32'(bus.ivalid), 32'd0);
        chk("mrst_req", 32'(bus.mem_req), 32'd0);
        chk("mrst_idata", bus.idata, 32'h0);
        q.delete();
        next_iaddr     = RV;
        bus.iaddr      = RV;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        @(negedge clk);
        rstn    = 1'b1;
        rv_pct  = 100;
        gnt_pct = 100;
        #1;
        chk("mrst_refetch_req", 32'(bus.mem_req), 32'd1);
        chk("mrst_refetch_addr", bus.mem_addr, RV);
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("mrst_vld_after", 32'(s_vld), 32'(n == 2));
        end

        // Sequential run across the 32-bit address wrap
        next_iaddr = 32'hFFFF_FFF8;
        mode       = 1;
        reached    = 1'b0;
        for (int n = 0; n < 60; n++) begin
            tick();
            if (s_vld && s_iaddr == 32'h8) begin
                reached = 1'b1;
                break;
            end
        end
        chk("wrap_reach", 32'(reached), 32'd1);

        // Random branches, random grant and response timing
        mode      = 2;
        gnt_pct   = 70;
        rv_pct    = 60;
        max_stall = 0;
        repeat (3000) tick();
        chk("progress", 32'(max_stall <= 100), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
